sync_mr_alloc: RTL and testbench
================================

// Module: sync_mr_alloc
// PURPOSE
//  Clocked multi-resource allocator: matches N requesting clients to M free resources, e.g.
//  routing requests to free SDM sub-channels at a clocked router or network-interface edge.
//  Makes at most one client/resource match per cycle, using round-robin on both sides.
//  Holds each match in a registered configuration matrix until the client releases it.
//  The matrix drives the crossbar select lines.
// PARAMETERS
//  N  4  number of clients (>=2)
//  M  4  number of resources (>=2)
// PORTS
//  clk     in   1    rising-edge clock
//  rst     in   1    synchronous, active-high reset
//  c_req   in   N    client request, level; held high while allocation is wanted
//  c_ack   out  N    client granted; high while client owns a resource
//  r_req   in   M    resource free/offered, level
//  r_ack   out  M    resource allocated; high while owned by a client
//  cfg     out  M*N  match matrix, flat; cfg[i*N+j]=1 <=> resource i owned by client j
//  err     out  1    sticky protocol-violation flag
// BEHAVIOUR
//  Reset (sync, dominant over all other events)
//   - cfg, c_ack, r_ack and err all go to 0; cptr=0, rptr=0.
//   - Reset mid-operation drops every allocation at that edge.
//  Handshake (four-phase on both sides)
//   - Client: raise c_req; wait c_ack=1; hold; drop c_req to release; wait c_ack=0 before re-raising.
//   - Resource: raise r_req; r_ack=1 marks it allocated; r_req must stay high while r_ack=1.
//  Eligibility (evaluated each cycle on registered state)
//   - Client j eligible: c_req[j] & ~c_ack[j].
//   - Resource i eligible: r_req[i] & ~r_ack[i].
//  Match
//   - Condition: at least one eligible client and at least one eligible resource.
//   - Client winner: first eligible index at or after cptr, wrapping N-1 -> 0.
//   - Resource winner: first eligible index at or after rptr, wrapping M-1 -> 0.
//   - Next edge: set cfg[ri*N+cj], c_ack[cj] and r_ack[ri].
//   - Pointers: cptr <= (cj+1) mod N; rptr <= (ri+1) mod M.
//   - No match in a cycle: pointers unchanged.
//   - Latency: one cycle from eligibility to ack.
//  Release
//   - Trigger: c_ack[j]=1 and c_req[j]=0.
//   - Next edge: clear column j of cfg, c_ack[j], and r_ack of the owning resource.
//   - A freed resource and client become eligible only in the following cycle.
//   - Never re-granted on the release edge.
//  Simultaneous events
//   - Release of one pair and match of a different pair may occur on the same edge.
//   - All N releases may occur on the same edge.
//  Invariants
//   - Each cfg row and each cfg column is at most one-hot.
//   - c_ack[j] = OR of column j of cfg.
//   - r_ack[i] = OR of row i of cfg.
//   - All outputs registered.
//  Protocol violation
//   - r_req[i]=0 while r_ack[i]=1 sets err=1 at the next edge.
//   - The allocation is kept until client release.
//   - err clears only on rst.
//  Full/empty
//   - All resources owned, or no eligible client: no change.
//   - Pending clients wait indefinitely.
//   - Round-robin bounds wait to N-1 grants once a resource frees.
// TESTING (N=4, M=4)
//  1. rst=1 for 2 cycles with random c_req/r_req -> cfg=0, c_ack=0, r_ack=0, err=0.
//  2. From reset: c_req=0001, r_req=0100 -> next edge cfg=16'h0100, c_ack=0001, r_ack=0100.
//  3. From reset: c_req=1111, r_req=1111 -> pairs c0-r0, c1-r1, c2-r2, c3-r3 on 4 consecutive edges.
//     Final cfg=16'h8421.
//  4. After test 3, drop c_req[0]: next edge c_ack=1110, r_ack=1110, cfg=16'h8420.
//     Re-raise c_req[0] after c_ack[0]=0: regrant to r0 one edge later.
//  5. c_req=1111 held, r_req=0001; each winner releases 3 cycles after grant.
//     Required grant order: c0,c1,c2,c3,c0; no client ever granted twice before all others.
//  6. After a c1-r1 match, drop r_req[1]: err=1 next edge; cfg bit 5 stays set.
//     err stays 1 until rst.

Source files
------------

// File: rtl/sync_mr_alloc.sv
// sync_mr_alloc: round-robin N-client / M-resource allocator with registered match matrix
module sync_mr_alloc #(
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   c_req,
    output logic [N-1:0]   c_ack,
    input  logic [M-1:0]   r_req,
    output logic [M-1:0]   r_ack,
    output logic [M*N-1:0] cfg,
    output logic           err
);
    localparam int CW = $clog2(N);
    localparam int RW = $clog2(M);
    logic [M-1:0][N-1:0] cfg_q, cfg_n;
    logic [CW-1:0] cptr, cj, ck;
    logic [RW-1:0] rptr, ri, rk;
    logic cfound, rfound;
    logic [N-1:0] c_elig, rel, ca_n;
    logic [M-1:0] r_elig, ra_n;
    assign cfg = cfg_q;
    // Releasing pairs still hold their acks this cycle, so they can never be re-matched on the release edge
    always_comb begin
        c_elig = c_req & ~c_ack;
        r_elig = r_req & ~r_ack;
        rel = c_ack & ~c_req;
        cfound = 1'b0;
        cj = '0;
        ck = '0;
        for (int k = 0; k < N; k++) begin
            ck = CW'((int'(cptr) + k) % N);
            if (!cfound && c_elig[ck]) begin
                cfound = 1'b1;
                cj = ck;
            end
        end
        rfound = 1'b0;
        ri = '0;
        rk = '0;
        for (int k = 0; k < M; k++) begin
            rk = RW'((int'(rptr) + k) % M);
            if (!rfound && r_elig[rk]) begin
                rfound = 1'b1;
                ri = rk;
            end
        end
        for (int i = 0; i < M; i++) cfg_n[i] = cfg_q[i] & ~rel;
        if (cfound && rfound) cfg_n[ri][cj] = 1'b1;
        ca_n = '0;
        ra_n = '0;
        for (int i = 0; i < M; i++) begin
            ca_n = ca_n | cfg_n[i];
            ra_n[i] = |cfg_n[i];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q <= '0;
            c_ack <= '0;
            r_ack <= '0;
            err   <= 1'b0;
            cptr  <= '0;
            rptr  <= '0;
        end else begin
            cfg_q <= cfg_n;
            c_ack <= ca_n;
            r_ack <= ra_n;
            err   <= err | (|(r_ack & ~r_req));
            if (cfound && rfound) begin
                cptr <= (cj == CW'(N - 1)) ? '0 : cj + 1'b1;
                rptr <= (ri == RW'(M - 1)) ? '0 : ri + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sync_mr_alloc.sv
// tb_sync_mr_alloc: directed checks of the allocator at N=M=4
module tb_sync_mr_alloc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] c_req = '0, c_ack, r_req = '0, r_ack;
    logic [15:0] cfg;
    logic err;
    int checks = 0, errors = 0;

    sync_mr_alloc #(.N(4), .M(4)) dut (
        .clk(clk), .rst(rst), .c_req(c_req), .c_ack(c_ack),
        .r_req(r_req), .r_ack(r_ack), .cfg(cfg), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        // 1: reset with random requests
        #1;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            c_req = 4'($urandom);
            r_req = 4'($urandom);
            step();
        end
        check("rst_cfg", cfg, 16'h0);
        check("rst_cack", {12'h0, c_ack}, 16'h0);
        check("rst_rack", {12'h0, r_ack}, 16'h0);
        check("rst_err", {15'h0, err}, 16'h0);

        // 2: single request, offset resource
        c_req = 4'b0001;
        r_req = 4'b0100;
        rst = 1'b0;
        step();
        check("t2_cfg", cfg, 16'h0100);
        check("t2_cack", {12'h0, c_ack}, 16'h0001);
        check("t2_rack", {12'h0, r_ack}, 16'h0004);

        // 3: full load pairs up diagonally
        c_req = 4'b0000;
        r_req = 4'b0000;
        do_reset();
        c_req = 4'b1111;
        r_req = 4'b1111;
        step();
        check("t3_cfg1", cfg, 16'h0001);
        step();
        check("t3_cfg2", cfg, 16'h0021);
        step();
        check("t3_cfg3", cfg, 16'h0421);
        step();
        check("t3_cfg4", cfg, 16'h8421);
        step();
        check("t3_hold", cfg, 16'h8421);

        // 4: release c0, then regrant to r0
        c_req = 4'b1110;
        step();
        check("t4_cack", {12'h0, c_ack}, 16'h000e);
        check("t4_rack", {12'h0, r_ack}, 16'h000e);
        check("t4_cfg", cfg, 16'h8420);
        c_req = 4'b1111;
        step();
        check("t4_regrant", cfg, 16'h8421);
        check("t4_cack2", {12'h0, c_ack}, 16'h000f);

        // 5: single resource shared fairly
        c_req = 4'b0000;
        r_req = 4'b0000;
        do_reset();
        c_req = 4'b1111;
        r_req = 4'b0001;
        for (int g = 0; g < 5; g++) begin
            step();
            check($sformatf("t5_grant%0d", g), {12'h0, c_ack}, 16'(1 << (g % 4)));
            check($sformatf("t5_cfg%0d", g), cfg, 16'(1 << (g % 4)));
            step();
            step();
            c_req[g % 4] = 1'b0;
            step();
            check($sformatf("t5_rel%0d", g), {12'h0, c_ack}, 16'h0);
            c_req = 4'b1111;
        end

        // 6: resource withdrawn while owned
        c_req = 4'b0000;
        r_req = 4'b0000;
        do_reset();
        c_req = 4'b0011;
        r_req = 4'b0011;
        step();
        step();
        check("t6_cfg", cfg, 16'h0021);
        check("t6_err0", {15'h0, err}, 16'h0);
        r_req = 4'b0001;
        step();
        check("t6_err1", {15'h0, err}, 16'h1);
        check("t6_keep", cfg, 16'h0021);
        r_req = 4'b0011;
        step();
        step();
        check("t6_sticky", {15'h0, err}, 16'h1);
        do_reset();
        check("t6_clr", {15'h0, err}, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
